// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg
// Shared constants for the stopwatch controller slice.
//   - State encoding, which is also the value driven on the mode output.
//   - BCD digit limits for the seconds field.
//   - Adjust field-select codes for the sw_sel switch.
//   - bcd_inc: increments a two-digit BCD field with wrap at a given maximum.
// ---------------------------------------------------------------------------
package stopwatch_pkg;

  // State codes; the controller drives these directly onto its mode port.
  localparam logic [1:0] ST_PAUSED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_ADJUST = 2'd2;

  // BCD digit limits: seconds tens stop at 5, any ones digit stops at 9.
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // sw_sel codes for the field edited in adjust mode.
  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  // Increment a two-digit BCD value {tens, ones}. When the value equals
  // max_val it wraps to 00 and bit 8 of the result flags the wrap, so the
  // caller can use it as a carry into the next field.
  function automatic logic [8:0] bcd_inc(input logic [7:0] val,
                                         input logic [7:0] max_val);
    logic [8:0] res;
    res = 9'd0;
    if (val == max_val) begin
      res = {1'b1, 8'h00};
    end else if (val[3:0] >= DIGIT_MAX) begin
      res = {1'b0, val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {1'b0, val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_edge_pulse.sv
// ---------------------------------------------------------------------------
// edge_pulse
// Two-flop level-to-pulse converter. The sample flop (s1) captures the input
// level, the history flop (s2) holds the previous sample; the pulse is
// s1 & ~s2, exactly one clock wide per rising edge of the input level.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  asynchronous active-high reset, clears both flops
//   level_in in  1  level to watch
//   pulse    out 1  one-cycle pulse after each rising edge of level_in
// ---------------------------------------------------------------------------
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = level_in;
    s2_d = s1_q;
  end

  // Both flops clear on reset, so a level already high at release looks
  // like a fresh rising edge on the first cycle afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign pulse = s1_q & ~s2_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencing controller for the stopwatch datapath: run/pause/adjust state
// machine, MM:SS BCD count and adjust-mode blink flag.
// Parameters:
//   MAX_MIN  highest minute value before wrapping to 00 (1..99)
// Ports:
//   clk        in  1  system clock
//   rst        in  1  asynchronous active-high reset
//   clk_1hz    in  1  1 Hz divider level; rising edge = one counting tick
//   clk_fast   in  1  fast divider level; rising edge = one adjust step
//   btn_pause  in  1  debounced button; rising edge toggles run/pause
//   btn_clear  in  1  debounced button; while high clears count, forces pause
//   sw_adj     in  1  adjust-mode switch
//   sw_sel     in  1  adjust field: 0 = minutes, 1 = seconds
//   min_tens, min_ones, sec_tens, sec_ones  out 4  BCD digits
//   running    out 1  high in RUN
//   blink      out 1  toggles per 1 Hz event in ADJUST, else 0
//   mode       out 2  PAUSED=0, RUN=1, ADJUST=2
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       clk_fast,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink,
  output logic [1:0] mode
);

  // Wrap points of the two BCD fields.
  localparam logic [7:0] MIN_MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] SEC_MAX_BCD = {SEC_TENS_MAX, DIGIT_MAX};

  logic tick_ev;
  logic fast_ev;
  logic pause_ev;

  logic [1:0] state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic [7:0] min_q, min_d;
  logic       blink_q, blink_d;

  logic [8:0] sec_inc;
  logic [8:0] min_inc;

  edge_pulse u_tick_edge (
    .clk      (clk),
    .rst      (rst),
    .level_in (clk_1hz),
    .pulse    (tick_ev)
  );

  edge_pulse u_fast_edge (
    .clk      (clk),
    .rst      (rst),
    .level_in (clk_fast),
    .pulse    (fast_ev)
  );

  edge_pulse u_pause_edge (
    .clk      (clk),
    .rst      (rst),
    .level_in (btn_pause),
    .pulse    (pause_ev)
  );

  assign sec_inc = bcd_inc(sec_q, SEC_MAX_BCD);
  assign min_inc = bcd_inc(min_q, MIN_MAX_BCD);

  // Next-state logic. Clear dominates, then the adjust switch, then the
  // pause event. Adjust steps and blink toggles only act once the machine is
  // already in ADJUST, so a fast event that lands on the entry cycle is
  // dropped. In RUN a tick is counted even when a pause event arrives in the
  // same cycle; from PAUSED the coincident tick is ignored.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    blink_d = 1'b0;

    if (btn_clear) begin
      state_d = ST_PAUSED;
      sec_d   = 8'h00;
      min_d   = 8'h00;
    end else if (sw_adj) begin
      state_d = ST_ADJUST;
      if (state_q == ST_ADJUST) begin
        blink_d = blink_q ^ tick_ev;
        if (fast_ev) begin
          if (sw_sel == SEL_MIN) begin
            min_d = min_inc[7:0];
          end else begin
            sec_d = sec_inc[7:0];
          end
        end
      end
    end else begin
      case (state_q)
        ST_PAUSED: begin
          if (pause_ev) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick_ev) begin
            sec_d = sec_inc[7:0];
            if (sec_inc[8]) begin
              min_d = min_inc[7:0];
            end
          end
          if (pause_ev) begin
            state_d = ST_PAUSED;
          end
        end
        default: begin
          state_d = ST_PAUSED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_PAUSED;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      blink_q <= blink_d;
    end
  end

  assign min_tens = min_q[7:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[7:4];
  assign sec_ones = sec_q[3:0];
  assign running  = (state_q == ST_RUN);
  assign blink    = blink_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl. A second instance with MAX_MIN=5
// shares all inputs and is checked where the minute wrap point matters.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1hz, clk_fast, btn_pause, btn_clear, sw_adj, sw_sel;

  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blink;
  logic [1:0] mode;

  logic [3:0] s_min_tens, s_min_ones, s_sec_tens, s_sec_ones;
  logic       s_running, s_blink;
  logic [1:0] s_mode;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       p, t, f, c, a, s;
    logic [3:0] mt, mo, st, so;
    logic       run, bl;
    logic [1:0] md;
    string      name;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MAX_MIN(59)) dut (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .clk_fast(clk_fast),
    .btn_pause(btn_pause), .btn_clear(btn_clear), .sw_adj(sw_adj),
    .sw_sel(sw_sel), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running),
    .blink(blink), .mode(mode)
  );

  stopwatch_ctrl #(.MAX_MIN(5)) dut_small (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .clk_fast(clk_fast),
    .btn_pause(btn_pause), .btn_clear(btn_clear), .sw_adj(sw_adj),
    .sw_sel(sw_sel), .min_tens(s_min_tens), .min_ones(s_min_ones),
    .sec_tens(s_sec_tens), .sec_ones(s_sec_ones), .running(s_running),
    .blink(s_blink), .mode(s_mode)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare every output of the MAX_MIN=59 instance against expectations.
  task automatic checkOutput(input string name,
                             input logic [3:0] mt, mo, st, so,
                             input logic run, bl, input logic [1:0] md);
    logic [19:0] got, exp;
    got = {min_tens, min_ones, sec_tens, sec_ones, running, blink, mode};
    exp = {mt, mo, st, so, run, bl, md};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h (mm:ss run blink mode)",
               name, got, exp);
    end
  endtask

  // Compare the digits of the MAX_MIN=5 instance.
  task automatic checkSmall(input string name, input logic [3:0] mt, mo, st, so);
    logic [15:0] got, exp;
    got = {s_min_tens, s_min_ones, s_sec_tens, s_sec_ones};
    exp = {mt, mo, st, so};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h required %h (mm:ss, MAX_MIN=5)",
               name, got, exp);
    end
  endtask

  // Set levels, raise the requested pulse inputs for one cycle, drop them and
  // wait one more cycle so the resulting event has been applied.
  task automatic applyStimulus(input logic p, t, f, c, a, s);
    btn_clear = c;
    sw_adj    = a;
    sw_sel    = s;
    btn_pause = p;
    clk_1hz   = t;
    clk_fast  = f;
    step(1);
    btn_pause = 1'b0;
    clk_1hz   = 1'b0;
    clk_fast  = 1'b0;
    step(1);
  endtask

  task automatic pulseInputs(input logic p, t, f);
    applyStimulus(p, t, f, btn_clear, sw_adj, sw_sel);
  endtask

  task automatic pulseFast(input int n);
    for (int i = 0; i < n; i++) pulseInputs(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Vector table: pulse inputs p/t/f, levels c/a/s, then expected outputs.
    vecs[0]  = '{0,0,0,1,0,0, 0,0,0,0, 0,0,2'd0, "clear_from_run"};
    vecs[1]  = '{0,1,0,1,0,0, 0,0,0,0, 0,0,2'd0, "clear_holds_tick"};
    vecs[2]  = '{1,0,0,0,0,0, 0,0,0,0, 1,0,2'd1, "pause_to_run"};
    vecs[3]  = '{0,1,0,0,0,0, 0,0,0,1, 1,0,2'd1, "run_tick1"};
    vecs[4]  = '{0,1,0,0,0,0, 0,0,0,2, 1,0,2'd1, "run_tick2"};
    vecs[5]  = '{1,0,0,0,0,0, 0,0,0,2, 0,0,2'd0, "run_to_paused"};
    vecs[6]  = '{0,1,0,0,0,0, 0,0,0,2, 0,0,2'd0, "paused_tick_ignored"};
    vecs[7]  = '{0,0,1,0,0,0, 0,0,0,2, 0,0,2'd0, "paused_fast_ignored"};
    vecs[8]  = '{0,0,0,0,1,0, 0,0,0,2, 0,0,2'd2, "enter_adjust"};
    vecs[9]  = '{0,0,1,0,1,0, 0,1,0,2, 0,0,2'd2, "adj_min_step"};
    vecs[10] = '{0,0,1,0,1,1, 0,1,0,3, 0,0,2'd2, "adj_sec_step"};
    vecs[11] = '{0,1,0,0,1,1, 0,1,0,3, 0,1,2'd2, "blink_on"};
    vecs[12] = '{0,1,0,0,1,1, 0,1,0,3, 0,0,2'd2, "blink_off"};
    vecs[13] = '{0,1,0,0,1,1, 0,1,0,3, 0,1,2'd2, "blink_on2"};
    vecs[14] = '{0,0,0,0,0,1, 0,1,0,3, 0,0,2'd0, "leave_adjust"};
    vecs[15] = '{1,0,0,0,1,1, 0,1,0,3, 0,0,2'd2, "adj_beats_pause"};
    vecs[16] = '{0,0,0,0,0,1, 0,1,0,3, 0,0,2'd0, "leave_adjust2"};
    vecs[17] = '{0,0,0,1,1,1, 0,0,0,0, 0,0,2'd0, "clear_beats_adj"};
    vecs[18] = '{0,0,0,0,0,0, 0,0,0,0, 0,0,2'd0, "idle_after_clear"};

    rst = 1'b1;
    clk_1hz = 1'b0; clk_fast = 1'b0; btn_pause = 1'b0;
    btn_clear = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    step(2);
    checkOutput("reset_state", 0,0,0,0, 0,0,2'd0);
    rst = 1'b0;
    step(2);
    checkOutput("after_release", 0,0,0,0, 0,0,2'd0);

    // Start running and count 61 seconds.
    pulseInputs(1'b1, 1'b0, 1'b0);
    checkOutput("run_start", 0,0,0,0, 1,0,2'd1);
    for (int i = 0; i < 61; i++) pulseInputs(1'b0, 1'b1, 1'b0);
    checkOutput("count_0101", 0,1,0,1, 1,0,2'd1);
    checkSmall("count_0101_small", 0,1,0,1);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].p, vecs[i].t, vecs[i].f,
                    vecs[i].c, vecs[i].a, vecs[i].s);
      checkOutput(vecs[i].name, vecs[i].mt, vecs[i].mo, vecs[i].st,
                  vecs[i].so, vecs[i].run, vecs[i].bl, vecs[i].md);
    end

    // Preload 59:59 through adjust (small instance ends at 05:59), then tick.
    sw_adj = 1'b1; sw_sel = 1'b0;
    step(2);
    pulseFast(59);
    sw_sel = 1'b1;
    pulseFast(59);
    checkOutput("preload_5959", 5,9,5,9, 0,0,2'd2);
    checkSmall("preload_0559_small", 0,5,5,9);
    sw_adj = 1'b0;
    step(2);
    pulseInputs(1'b1, 1'b0, 1'b0);
    pulseInputs(1'b0, 1'b1, 1'b0);
    checkOutput("wrap_5959", 0,0,0,0, 1,0,2'd1);
    checkSmall("wrap_0559_small", 0,0,0,0);

    // Seconds adjust wrap from 00:58 and blink behaviour.
    btn_clear = 1'b1; step(2); btn_clear = 1'b0;
    sw_adj = 1'b1; sw_sel = 1'b1;
    step(2);
    pulseFast(58);
    checkOutput("adj_0058", 0,0,5,8, 0,0,2'd2);
    pulseFast(3);
    checkOutput("adj_sec_wrap", 0,0,0,1, 0,0,2'd2);
    for (int i = 0; i < 3; i++) begin
      pulseInputs(1'b0, 1'b1, 1'b0);
      checkOutput("blink_toggle", 0,0,0,1, 0,(i % 2 == 0),2'd2);
    end
    sw_adj = 1'b0;
    step(2);
    checkOutput("blink_cleared", 0,0,0,1, 0,0,2'd0);

    // Coincident pause and tick events, from RUN then from PAUSED.
    sw_adj = 1'b1; sw_sel = 1'b1;
    step(2);
    pulseFast(9);
    sw_adj = 1'b0;
    step(2);
    pulseInputs(1'b1, 1'b0, 1'b0);
    checkOutput("run_0010", 0,0,1,0, 1,0,2'd1);
    pulseInputs(1'b1, 1'b1, 1'b0);
    checkOutput("coinc_from_run", 0,0,1,1, 0,0,2'd0);
    pulseInputs(1'b1, 1'b1, 1'b0);
    checkOutput("coinc_from_paused", 0,0,1,1, 1,0,2'd1);

    // Clear arriving with a tick while running at 03:27.
    pulseInputs(1'b1, 1'b0, 1'b0);
    sw_adj = 1'b1; sw_sel = 1'b0;
    step(2);
    pulseFast(3);
    sw_sel = 1'b1;
    pulseFast(16);
    sw_adj = 1'b0;
    step(2);
    pulseInputs(1'b1, 1'b0, 1'b0);
    checkOutput("run_0327", 0,3,2,7, 1,0,2'd1);
    btn_clear = 1'b1; clk_1hz = 1'b1;
    step(2);
    checkOutput("clear_coinc_tick", 0,0,0,0, 0,0,2'd0);
    clk_1hz = 1'b0;
    step(1);
    pulseInputs(1'b0, 1'b1, 1'b0);
    pulseInputs(1'b1, 1'b1, 1'b0);
    checkOutput("clear_frozen", 0,0,0,0, 0,0,2'd0);
    btn_clear = 1'b0;
    step(2);

    // Fast event on the ADJUST entry cycle is dropped.
    clk_fast = 1'b1;
    step(1);
    sw_adj = 1'b1; sw_sel = 1'b1;
    step(1);
    clk_fast = 1'b0;
    step(1);
    checkOutput("entry_no_step", 0,0,0,0, 0,0,2'd2);
    pulseFast(1);
    checkOutput("first_step", 0,0,0,1, 0,0,2'd2);
    sw_adj = 1'b0;
    step(2);

    // Asynchronous reset mid-count, then release with levels held high.
    pulseInputs(1'b1, 1'b0, 1'b0);
    pulseInputs(1'b0, 1'b1, 1'b0);
    pulseInputs(1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset", 0,0,0,3, 1,0,2'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 0,0,0,0, 0,0,2'd0);
    clk_1hz = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    checkOutput("release_tick_paused", 0,0,0,0, 0,0,2'd0);
    rst = 1'b1; btn_pause = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    checkOutput("release_pause_tick", 0,0,0,0, 1,0,2'd1);
    clk_1hz = 1'b0; btn_pause = 1'b0;
    step(2);
    pulseInputs(1'b0, 1'b1, 1'b0);
    checkOutput("after_release_tick", 0,0,0,1, 1,0,2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
